// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus initiator that copies len words from src_addr to dst_addr
// over a shared single-port memory bus, one word per read cycle plus write cycle.
// Latency: N>=1 words -> done pulses in cycle 2N+1 after the start edge; N=0 -> cycle 1.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE.
//
// Ports:
//   clock, reset_L           rising-edge clock, asynchronous active-low reset
//   start                    copy request, accepted only in IDLE
//   src_addr, dst_addr, len  operands, latched when start is accepted (len==0 is a no-op)
//   busy                     high while the copy is reading or writing
//   done                     one-cycle completion pulse (DONE state)
//   remaining                words still to be copied
//   addr, re, we             memory address and strobes, decoded from the state
//   data                     shared bidirectional bus, driven by the engine only while we=1
//
// Optional feature (macro MEM_COPY_ABORT_EN):
//   abort                    stop the copy early; in READ the read is discarded, in WRITE the
//                            current write still completes before the engine stops
//   aborted                  high only during the DONE cycle of an aborted copy

module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
`ifdef MEM_COPY_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] remaining,
    output logic [AW-1:0] addr,
    output logic          re,
    output logic          we,
    inout  wire  [DW-1:0] data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] rem_q;
    logic [DW-1:0] hold_reg;

    // Internal abort request; tied low when the abort feature is not built in.
    logic          abort_req;

`ifdef MEM_COPY_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and bus decode. All bus outputs depend on the state and
    // registered pointers only, so reset releases the bus immediately.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        re        = 1'b0;
        we        = 1'b0;
        addr      = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_READ;
                end
            end

            S_READ: begin
                busy      = 1'b1;
                re        = 1'b1;
                addr      = src_ptr;
                state_nxt = abort_req ? S_DONE : S_WRITE;
            end

            S_WRITE: begin
                busy = 1'b1;
                we   = 1'b1;
                addr = dst_ptr;
                // rem_q==1 means this write is the last word of the copy.
                if ((rem_q == AW'(1)) || abort_req) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_READ;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, pointer/count update, read data capture.
    // Pointers wrap naturally modulo 2^AW.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            rem_q    <= '0;
            hold_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        rem_q   <= len;
                    end
                end

                S_READ: begin
                    // Memory drives the bus combinationally during READ.
                    // An aborted read is simply never written back.
                    hold_reg <= data;
                end

                S_WRITE: begin
                    src_ptr <= src_ptr + AW'(1);
                    dst_ptr <= dst_ptr + AW'(1);
                    rem_q   <= rem_q - AW'(1);
                end

                default: begin
                end
            endcase
        end
    end

`ifdef MEM_COPY_ABORT_EN
    // Remembers that the current copy was cut short, so DONE can report it.
    logic aborted_q;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            aborted_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        aborted_q <= 1'b0;
                    end
                end
                S_READ, S_WRITE: begin
                    if (abort_req) begin
                        aborted_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign aborted = (state == S_DONE) && aborted_q;
`endif

    assign remaining = rem_q;

    // The engine owns the bus only in WRITE; otherwise it is released.
    assign data = we ? hold_reg : {DW{1'bz}};

endmodule
